// File: rtl/risc_pkg.sv
// Shared fetch-stage types: FSM state encoding and the {pc,instr} entry carried to decode.
package risc_pkg;

  localparam int unsigned INST_ADDR_W = 12;
  localparam int unsigned INST_DATA_W = 32;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the IMEM response and decode; head holds the last popped
// value when empty so the presented pc/instr never float.
module fetch_skid_fifo #(
  parameter int unsigned W = 44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop && cnt_q == 2'd2)
        e0_q <= e1_q;
      // New data lands in the head slot when it is (or is becoming) the only entry.
      if (push) begin
        if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))
          e0_q <= din;
        else
          e1_q <= din;
      end
    end
  end

  assign dout  = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC/FSM ownership, credit-based IMEM issue with 1-cycle read
// latency, and a valid/ready hand-off of {pc,instr} to decode.
module inst_fetch_unit #(
  parameter int unsigned            INST_ADDR_W = 12,
  parameter int unsigned            INST_DATA_W = 32,
  parameter logic [INST_ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned            CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_en,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic [INST_DATA_W-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  input  logic                   halt,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_DATA_W-1:0] if_instr,
  output logic                   halted,
  output logic [CNT_W-1:0]       fetch_cnt
);

  import risc_pkg::*;

  localparam int unsigned EW = INST_ADDR_W + INST_DATA_W;

  fetch_state_e           state_q;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] inflight_pc_q;
  logic                   inflight_q;
  logic [CNT_W-1:0]       fetch_cnt_q;

  logic [1:0]    count;
  logic [2:0]    credit;
  logic          pop, push, issue;
  logic [EW-1:0] head;

  assign if_valid = (count != 2'd0) && !redirect_valid;
  assign pop      = if_valid && if_ready;
  assign push     = inflight_q && !redirect_valid;

  // Occupancy after this cycle's pop; counting the in-flight read keeps the FIFO from
  // ever overflowing, and the if_ready term lets issue continue with no bubble.
  assign credit = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == S_RUN) && !halt && !redirect_valid && (credit < 3'd2);

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign if_pc     = head[EW-1:INST_DATA_W];
  assign if_instr  = head[INST_DATA_W-1:0];
  assign halted    = (state_q == S_HALT) && (count == 2'd0) && !inflight_q;
  assign fetch_cnt = fetch_cnt_q;

  fetch_skid_fifo #(
    .W(EW)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({inflight_pc_q, imem_instr}),
    .pop  (pop),
    .flush(redirect_valid),
    .dout (head),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_BOOT:  state_q <= S_RUN;
        S_RUN:   if (halt && !redirect_valid) state_q <= S_HALT;
        S_HALT:  if (redirect_valid) state_q <= S_RUN;
        default: state_q <= S_BOOT;
      endcase

      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          inflight_pc_q <= pc_q;
          pc_q          <= pc_q + 1'b1;
        end
      end

      if (pop && fetch_cnt_q != '1)
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
    end
  end

endmodule
